reset_sequencer: RTL and testbench

//  Staged reset controller between clock-wizard lock and the game core. Synchronises

---
 rtl/reset_seq_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/reset_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_reset_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg
//  Shared definitions for the staged reset sequencer: the controller state
//  encoding and the helper that sizes the shared hold/gap/timeout counter.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_HOLD      = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_GAP       = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAULT     = 3'd6
  } state_e;

  // One counter serves all three waits, so it must hold the largest of them.
  function automatic int cnt_width(input int hold_cycles, input int gap_cycles,
                                   input int ack_timeout);
    int m;
    m = hold_cycles;
    if (gap_cycles > m) m = gap_cycles;
    if (ack_timeout > m) m = ack_timeout;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//  Two-flop synchroniser for a single slow level signal crossing into clk.
//  Ports:
//    clk    in  system clock
//    rst_n  in  synchronous active-low reset, clears both flops
//    d_i    in  asynchronous level input
//    q_o    out synchronised level, two clk cycles behind d_i
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state is assigned with non-blocking (<=) so both flops
  // sample their inputs at the same edge and form a real two-stage pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
//  Staged reset controller sitting between clock-wizard lock and the game core.
//  Waits for a stable synchronised lock, then releases NUM_STAGES reset domains
//  strictly in index order, waiting for each domain's ready ack and a short gap
//  before releasing the next. Lock loss or a soft reset request re-arms it.
//  Ports:
//    clk           in   system clock
//    rst_n         in   synchronous active-low reset
//    clock_locked  in   MMCM lock, asynchronous to clk
//    soft_rst_req  in   one-cycle user reset request (synchronous)
//    stage_ack     in   per-stage ready level after its reset is released
//    stage_rst     out  per-stage active-high reset
//    all_ready     out  every stage released and acked
//    fault         out  a stage failed to ack within ACK_TIMEOUT cycles
//    fault_stage   out  index of the stage that timed out (valid with fault)
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clock_locked,
  input  logic                  soft_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  all_ready,
  output logic                  fault,
  output logic [2:0]            fault_stage
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT);
  typedef logic [CNT_W-1:0] cnt_t;

  // Terminal counts: the counter starts at 0 on entry, so the last wait
  // cycle is reached at N-1.
  localparam cnt_t       HOLD_LAST = cnt_t'(HOLD_CYCLES - 1);
  localparam cnt_t       GAP_LAST  = cnt_t'(GAP_CYCLES - 1);
  localparam cnt_t       ACK_LAST  = cnt_t'(ACK_TIMEOUT - 1);
  localparam logic [2:0] IDX_LAST  = 3'(NUM_STAGES - 1);

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (clock_locked),
    .q_o   (lock_s)
  );

  state_e                state_q, state_d;
  cnt_t                  cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                  all_ready_q, all_ready_d;
  logic                  fault_q, fault_d;
  logic [2:0]            fault_stage_q, fault_stage_d;
  logic                  ack_sel;
  cnt_t                  cnt_inc;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + cnt_t'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_WAIT_LOCK;
      cnt_q         <= '0;
      idx_q         <= '0;
      stage_rst_q   <= '1;
      all_ready_q   <= 1'b0;
      fault_q       <= 1'b0;
      fault_stage_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      stage_rst_q   <= stage_rst_d;
      all_ready_q   <= all_ready_d;
      fault_q       <= fault_d;
      fault_stage_q <= fault_stage_d;
    end
  end

  // NOTE: every variable gets its hold value first so no path through the
  // case leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    stage_rst_d   = stage_rst_q;
    all_ready_d   = all_ready_q;
    fault_d       = fault_q;
    fault_stage_d = fault_stage_q;

    // Only the ack of the stage currently being waited on is looked at.
    ack_sel = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (3'(i) == idx_q) ack_sel = stage_ack[i];
    end

    if (state_q != ST_WAIT_LOCK && !lock_s) begin
      // Lock loss outranks everything, including a simultaneous soft request.
      state_d     = ST_WAIT_LOCK;
      cnt_d       = '0;
      idx_d       = '0;
      stage_rst_d = '1;
      all_ready_d = 1'b0;
      fault_d     = 1'b0;
    end else if (state_q != ST_WAIT_LOCK && soft_rst_req) begin
      // Lock is still good, so skip the lock wait and restart the hold count.
      state_d     = ST_HOLD;
      cnt_d       = '0;
      idx_d       = '0;
      stage_rst_d = '1;
      all_ready_d = 1'b0;
      fault_d     = 1'b0;
    end else begin
      unique case (state_q)
        ST_WAIT_LOCK: begin
          stage_rst_d = '1;
          cnt_d       = '0;
          if (lock_s) state_d = ST_HOLD;
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_RELEASE: begin
          for (int i = 0; i < NUM_STAGES; i++) begin
            if (3'(i) == idx_q) stage_rst_d[i] = 1'b0;
          end
          cnt_d   = '0;
          state_d = ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (ack_sel) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d     = ST_RUN;
              all_ready_d = 1'b1;
            end else begin
              state_d = ST_GAP;
            end
          end else if (cnt_q == ACK_LAST) begin
            // The silent stage goes back into reset; earlier stages stay up.
            state_d       = ST_FAULT;
            fault_d       = 1'b1;
            fault_stage_d = idx_q;
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (3'(i) == idx_q) stage_rst_d[i] = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
            idx_d   = idx_q + 3'd1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_RUN: begin
          stage_rst_d = '0;
          all_ready_d = 1'b1;
        end
        ST_FAULT: begin
          fault_d = 1'b1;
        end
        default: begin
          state_d     = ST_WAIT_LOCK;
          stage_rst_d = '1;
        end
      endcase
    end
  end

  assign stage_rst   = stage_rst_q;
  assign all_ready   = all_ready_q;
  assign fault       = fault_q;
  assign fault_stage = fault_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//  Self-checking bench for reset_sequencer. A timestamp-based reference model
//  (when the next release is due, when an ack deadline expires, how many stages
//  are released) predicts every registered output each cycle. Directed phases
//  cover reset, nominal sequencing, lock glitch, ack timeout, lock loss and the
//  soft/lock-loss collision; a randomized phase follows.
module tb_reset_sequencer;

  localparam int NS    = 3;
  localparam int HOLD  = 16;
  localparam int GAP   = 8;
  localparam int ACKTO = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clock_locked;
  logic          soft_rst_req;
  logic [NS-1:0] stage_ack;
  logic [NS-1:0] stage_rst;
  logic          all_ready;
  logic          fault;
  logic [2:0]    fault_stage;

  reset_sequencer #(
    .NUM_STAGES  (NS),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .ACK_TIMEOUT (ACKTO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clock_locked (clock_locked),
    .soft_rst_req (soft_rst_req),
    .stage_ack    (stage_ack),
    .stage_rst    (stage_rst),
    .all_ready    (all_ready),
    .fault        (fault),
    .fault_stage  (fault_stage)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;

  // Reference model state
  bit     m_ls1, m_ls2;
  bit     m_armed, m_ready, m_fault;
  int     m_nrel, m_fstage;
  longint m_next_rel, m_deadline;

  // Ack stimulus: each stage acks a programmable number of cycles after its
  // reset is seen low, unless withheld; force_ack drives an ack regardless.
  int          ack_delay [NS];
  int          low_cnt   [NS];
  logic [NS-1:0] withhold;
  logic [NS-1:0] force_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [NS-1:0] exp_rst(input int n);
    logic [NS-1:0] r;
    for (int i = 0; i < NS; i++) r[i] = (i >= n);
    return r;
  endfunction

  task automatic model_disarm();
    m_armed    = 1'b0;
    m_nrel     = 0;
    m_ready    = 1'b0;
    m_fault    = 1'b0;
    m_next_rel = -1;
    m_deadline = -1;
  endtask

  task automatic model_edge(input longint t);
    bit lock_s;
    lock_s = m_ls2;
    if (!rst_n) begin
      m_ls1 = 1'b0;
      m_ls2 = 1'b0;
      model_disarm();
      m_fstage = 0;
    end else begin
      m_ls2 = m_ls1;
      m_ls1 = clock_locked;
      if (m_armed && !lock_s) begin
        model_disarm();
      end else if (!m_armed) begin
        if (lock_s) begin
          m_armed    = 1'b1;
          m_next_rel = t + HOLD + 1;
        end
      end else if (soft_rst_req) begin
        m_nrel     = 0;
        m_ready    = 1'b0;
        m_fault    = 1'b0;
        m_deadline = -1;
        m_next_rel = t + HOLD + 1;
      end else if (m_fault || m_ready) begin
        // parked until lock loss or soft request
      end else if (m_next_rel == t) begin
        m_nrel++;
        m_next_rel = -1;
        m_deadline = t + ACKTO;
      end else if (m_deadline >= 0) begin
        if (stage_ack[m_nrel-1]) begin
          m_deadline = -1;
          if (m_nrel == NS) m_ready = 1'b1;
          else m_next_rel = t + GAP + 1;
        end else if (t == m_deadline) begin
          m_fault    = 1'b1;
          m_fstage   = m_nrel - 1;
          m_nrel     = m_nrel - 1;
          m_deadline = -1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge(cyc);
    #1;
    check("stage_rst", 32'(stage_rst), 32'(exp_rst(m_nrel)));
    check("all_ready", 32'(all_ready), 32'(m_ready));
    check("fault", 32'(fault), 32'(m_fault));
    if (m_fault) check("fault_stage", 32'(fault_stage), 32'(m_fstage));
    for (int i = 0; i < NS; i++) begin
      if (stage_rst[i] !== 1'b0) low_cnt[i] = 0;
      else if (low_cnt[i] < 100000) low_cnt[i]++;
      stage_ack[i] = force_ack[i] |
                     (!withhold[i] && (stage_rst[i] === 1'b0) && (low_cnt[i] >= ack_delay[i]));
    end
  endtask

  task automatic run_until_ready(input string tag);
    for (int k = 0; k < 300 && all_ready !== 1'b1; k++) step();
    check(tag, 32'(all_ready), 32'd1);
  endtask

  initial begin
    longint t0;
    int     lock_off;

    rst_n = 1'b0; clock_locked = 1'b1; soft_rst_req = 1'b0; stage_ack = '0;
    withhold = '0; force_ack = '0;
    for (int i = 0; i < NS; i++) begin ack_delay[i] = 3; low_cnt[i] = 0; end
    model_disarm(); m_fstage = 0; m_ls1 = 1'b0; m_ls2 = 1'b0;

    // 1: reset held with lock high
    repeat (5) step();
    check("reset_stage_rst", 32'(stage_rst), 32'h7);

    // 2: nominal sequence, 20-cycle lock-to-release latency
    rst_n = 1'b1; clock_locked = 1'b0;
    repeat (4) step();
    clock_locked = 1'b1; t0 = cyc;
    for (int k = 0; k < 100 && stage_rst[0] !== 1'b0; k++) step();
    check("lock_to_rel0", 32'(cyc - t0), 32'd20);
    run_until_ready("nominal_ready");
    check("nominal_all_rel", 32'(stage_rst), 32'h0);

    // 3: one-cycle lock glitch around hold count 10
    clock_locked = 1'b0;
    repeat (4) step();
    clock_locked = 1'b1;
    repeat (12) step();
    clock_locked = 1'b0;
    step();
    clock_locked = 1'b1; t0 = cyc;
    for (int k = 0; k < 100 && stage_rst[0] !== 1'b0; k++) step();
    check("glitch_restart", 32'(cyc - t0), 32'd20);
    run_until_ready("glitch_ready");

    // 4: stage 1 never acks -> timeout fault, then soft reset recovery
    withhold = 3'b010;
    soft_rst_req = 1'b1; step(); soft_rst_req = 1'b0;
    for (int k = 0; k < 200 && stage_rst[1] !== 1'b0; k++) step();
    t0 = cyc;
    for (int k = 0; k < 1100 && fault !== 1'b1; k++) step();
    check("timeout_latency", 32'(cyc - t0), 32'd1024);
    check("timeout_stage", 32'(fault_stage), 32'd1);
    check("timeout_rst", 32'(stage_rst), 32'h6);
    soft_rst_req = 1'b1; step(); soft_rst_req = 1'b0;
    check("soft_clears_fault", 32'(fault), 32'd0);
    check("soft_rst_all", 32'(stage_rst), 32'h7);
    withhold = '0;
    run_until_ready("fault_rerun_ready");

    // 5: lock loss in RUN takes effect three cycles later
    clock_locked = 1'b0;
    step(); step();
    check("lockloss_not_yet", 32'(all_ready), 32'd1);
    step();
    check("lockloss_rst", 32'(stage_rst), 32'h7);
    check("lockloss_ready", 32'(all_ready), 32'd0);
    clock_locked = 1'b1;
    run_until_ready("relock_ready");

    // 6: soft request coincides with lock loss; early ack of stage 2 ignored
    clock_locked = 1'b0;
    step(); step();
    soft_rst_req = 1'b1; step(); soft_rst_req = 1'b0;
    check("collide_rst", 32'(stage_rst), 32'h7);
    repeat (3) step();
    force_ack = 3'b100;
    clock_locked = 1'b1; t0 = cyc;
    for (int k = 0; k < 100 && stage_rst[0] !== 1'b0; k++) step();
    check("collide_relock", 32'(cyc - t0), 32'd20);
    for (int k = 0; k < 100 && stage_rst[1] !== 1'b0; k++) step();
    check("early_ack_order", 32'(stage_rst[2]), 32'd1);
    run_until_ready("early_ack_ready");
    force_ack = '0;

    // Randomized episodes
    lock_off = 0;
    for (int ep = 0; ep < 12; ep++) begin
      for (int i = 0; i < NS; i++) ack_delay[i] = int'($urandom_range(0, 12));
      withhold  = ($urandom_range(0, 3) == 0) ? NS'(1 << $urandom_range(0, NS - 1)) : '0;
      force_ack = ($urandom_range(0, 4) == 0) ? NS'($urandom_range(0, 7)) : '0;
      if ($urandom_range(0, 2) == 0) begin
        rst_n = 1'b0; step(); rst_n = 1'b1;
      end
      for (int c = 0; c < 1800; c++) begin
        if (lock_off > 0) begin
          clock_locked = 1'b0;
          lock_off--;
        end else begin
          clock_locked = 1'b1;
          if ($urandom_range(0, 599) == 0) lock_off = int'($urandom_range(1, 4));
        end
        soft_rst_req = ($urandom_range(0, 299) == 0);
        step();
      end
      soft_rst_req = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
